// File: rtl/arm_pkg.sv
// Shared definitions for the addressing-mode-1 operand generator:
// shift kinds, FSM states, instruction field positions and the latched work record.
package arm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned IDX_W  = 5;

  localparam int unsigned I_BIT         = 25;
  localparam int unsigned REG_SHIFT_BIT = 4;
  localparam int unsigned MULT_BIT      = 7;
  localparam int unsigned ROT_MSB       = 11;
  localparam int unsigned ROT_LSB       = 8;
  localparam int unsigned SHAMT_MSB     = 11;
  localparam int unsigned SHAMT_LSB     = 7;
  localparam int unsigned TYPE_MSB      = 6;
  localparam int unsigned TYPE_LSB      = 5;
  localparam int unsigned IMM_MSB       = 7;
  localparam int unsigned IMM_LSB       = 0;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Working state of one operation: value, remaining count, shift kind, fill and carry
  typedef struct packed {
    logic [DATA_W-1:0] w;
    logic [CNT_W-1:0]  n;
    shift_t            kind;
    logic              fill;
    logic              carry;
  } op_t;

endpackage

// File: rtl/shifter_step.sv
// One combinational shift/rotate step of 1..32 positions; carry is the last bit moved out.
module shifter_step
  import arm_pkg::*;
(
  input  logic [DATA_W-1:0] w,
  input  shift_t            kind,
  input  logic [CNT_W-1:0]  k,
  input  logic              fill,
  output logic [DATA_W-1:0] w_out,
  output logic              carry
);

  localparam logic [DATA_W-1:0] ONES = '1;

  logic [IDX_W-1:0] lsl_idx;
  logic [IDX_W-1:0] lsr_idx;

  assign lsl_idx = IDX_W'(CNT_W'(DATA_W) - k);
  assign lsr_idx = IDX_W'(k - CNT_W'(1));

  // ASR also serves RRX: a 1-bit right shift with an arbitrary fill bit
  always_comb begin
    w_out = w;
    carry = w[lsr_idx];
    case (kind)
      SH_LSL: begin
        w_out = w << k;
        carry = w[lsl_idx];
      end
      SH_LSR:  w_out = w >> k;
      SH_ASR:  w_out = (w >> k) | ({DATA_W{fill}} & ~(ONES >> k));
      default: w_out = (w >> k) | (w << (CNT_W'(DATA_W) - k));
    endcase
  end

endmodule

// File: rtl/shifter_operand_unit.sv
// Iterative ARM data-processing operand-2 generator with start/busy/done handshake.
// Decodes operand 2 on start, then shifts STEP bits per cycle until the count is exhausted.
module shifter_operand_unit
  import arm_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] rm_val,
  input  logic [DATA_W-1:0] rs_val,
  input  logic              c_in,
  output logic [DATA_W-1:0] shifter_operand,
  output logic              shifter_carry_out,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] STEP_K = CNT_W'(STEP);

  state_t            state_q, state_d;
  op_t               dec, work_q, work_d;
  logic [CNT_W-1:0]  k;
  logic [DATA_W-1:0] step_w;
  logic              step_c;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_out_q, carry_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [4:0]        amt;
  logic [7:0]        rs_amt;
  shift_t            typ;
  logic              unused_bits;

  assign amt         = instr[SHAMT_MSB:SHAMT_LSB];
  assign rs_amt      = rs_val[7:0];
  assign typ         = shift_t'(instr[TYPE_MSB:TYPE_LSB]);
  assign unused_bits = ^{rs_val[31:8], instr[31:26], instr[24:12], instr[3:0]};

  // Operand-2 decode: effective count, working value, fill and initial carry
  always_comb begin
    dec       = '0;
    dec.w     = rm_val;
    dec.kind  = typ;
    dec.carry = c_in;
    if (instr[I_BIT]) begin
      dec.w    = {24'b0, instr[IMM_MSB:IMM_LSB]};
      dec.kind = SH_ROR;
      dec.n    = {1'b0, instr[ROT_MSB:ROT_LSB], 1'b0};
    end else if (!instr[REG_SHIFT_BIT]) begin
      case (typ)
        SH_LSL: dec.n = CNT_W'(amt);
        SH_LSR: dec.n = (amt == '0) ? CNT_W'(DATA_W) : CNT_W'(amt);
        SH_ASR: begin
          dec.fill = rm_val[DATA_W-1];
          dec.n    = (amt == '0) ? CNT_W'(DATA_W) : CNT_W'(amt);
        end
        default: begin
          if (amt == '0) begin
            dec.kind = SH_ASR;
            dec.fill = c_in;
            dec.n    = CNT_W'(1);
          end else begin
            dec.n = CNT_W'(amt);
          end
        end
      endcase
    end else if (!instr[MULT_BIT] && (rs_amt != 8'd0)) begin
      case (typ)
        SH_LSL, SH_LSR: begin
          if (rs_amt > 8'd32) begin
            dec.w     = '0;
            dec.carry = 1'b0;
          end else begin
            dec.n = CNT_W'(rs_amt);
          end
        end
        SH_ASR: begin
          dec.fill = rm_val[DATA_W-1];
          dec.n    = (rs_amt >= 8'd32) ? CNT_W'(DATA_W) : CNT_W'(rs_amt);
        end
        default: begin
          if (rs_amt[4:0] == 5'd0) dec.carry = rm_val[DATA_W-1];
          else                     dec.n     = {1'b0, rs_amt[4:0]};
        end
      endcase
    end
  end

  assign k = (work_q.n < STEP_K) ? work_q.n : STEP_K;

  shifter_step u_step (
    .w     (work_q.w),
    .kind  (work_q.kind),
    .k     (k),
    .fill  (work_q.fill),
    .w_out (step_w),
    .carry (step_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (dec.n == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (work_q.n == k) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs
  always_comb begin
    work_d      = work_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    if ((state_q == S_IDLE) && start) begin
      work_d = dec;
    end else if (state_q == S_SHIFT) begin
      work_d.w     = step_w;
      work_d.carry = step_c;
      work_d.n     = work_q.n - k;
    end
    if (state_d == S_DONE) begin
      result_d    = work_d.w;
      carry_out_d = work_d.carry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q      <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      work_q      <= work_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign shifter_operand   = result_q;
  assign shifter_carry_out = carry_out_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Directed scoreboard bench: three instances (STEP 1, 8, 32) see the same stimulus.
module tb_shifter_operand_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rm_val = '0;
  logic [31:0] rs_val = '0;
  logic        c_in = 1'b0;

  logic [31:0] op1, op8, op32;
  logic        c1, c8, c32;
  logic        busy1, busy8, busy32;
  logic        done1, done8, done32;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] op;
    logic        c;
    int          lat;
    string       tag;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  shifter_operand_unit #(.STEP(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .rm_val(rm_val),
    .rs_val(rs_val), .c_in(c_in), .shifter_operand(op1), .shifter_carry_out(c1),
    .busy(busy1), .done(done1));

  shifter_operand_unit #(.STEP(8)) u_s8 (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .rm_val(rm_val),
    .rs_val(rs_val), .c_in(c_in), .shifter_operand(op8), .shifter_carry_out(c8),
    .busy(busy8), .done(done8));

  shifter_operand_unit #(.STEP(32)) u_s32 (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .rm_val(rm_val),
    .rs_val(rs_val), .c_in(c_in), .shifter_operand(op32), .shifter_carry_out(c32),
    .busy(busy32), .done(done32));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int n, input int step);
    return (n == 0) ? 1 : 1 + (n + step - 1) / step;
  endfunction

  function automatic logic [31:0] f_imm(input logic [3:0] rot, input logic [7:0] imm8);
    return {6'b0, 1'b1, 13'b0, rot, imm8};
  endfunction

  function automatic logic [31:0] f_ish(input logic [4:0] amt, input logic [1:0] typ);
    return {20'b0, amt, typ, 1'b0, 4'b0};
  endfunction

  function automatic logic [31:0] f_rsh(input logic [1:0] typ);
    return {20'b0, 4'b0, 1'b0, typ, 1'b1, 4'b0};
  endfunction

  task automatic pop_cmp(input int which, input logic [31:0] op, input logic c, input int e);
    exp_t x;
    int   sz;
    sz = (which == 1) ? q1.size() : (which == 8) ? q8.size() : q32.size();
    if (sz == 0) begin
      check($sformatf("s%0d_unexpected_done", which), 32'(sz), 32'd1);
      return;
    end
    if (which == 1)      x = q1.pop_front();
    else if (which == 8) x = q8.pop_front();
    else                 x = q32.pop_front();
    check($sformatf("%s_s%0d_op", x.tag, which), op, x.op);
    check($sformatf("%s_s%0d_carry", x.tag, which), 32'(c), 32'(x.c));
    check($sformatf("%s_s%0d_lat", x.tag, which), 32'(e), 32'(x.lat));
  endtask

  // Quiet cycles after an operation: no done pulse, not busy, start released
  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_done"}, 32'({done1, done8, done32}), 32'd0);
      check({tag, "_idle_busy"}, 32'({busy1, busy8, busy32}), 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] i_w, input logic [31:0] rm,
                        input logic [31:0] rs, input logic cin, input logic [31:0] e_op,
                        input logic e_c, input int n, input int hold);
    bit g1, g8, g32;
    @(negedge clk);
    instr  = i_w;
    rm_val = rm;
    rs_val = rs;
    c_in   = cin;
    start  = 1'b1;
    q1.push_back('{op: e_op, c: e_c, lat: lat_of(n, 1), tag: tag});
    q8.push_back('{op: e_op, c: e_c, lat: lat_of(n, 8), tag: tag});
    q32.push_back('{op: e_op, c: e_c, lat: lat_of(n, 32), tag: tag});
    g1 = 0; g8 = 0; g32 = 0;
    for (int e = 1; e <= 60 && !(g1 && g8 && g32); e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e >= hold) start = 1'b0;
      if (e == 1 && n > 0) check({tag, "_s1_busy"}, 32'(busy1), 32'd1);
      if (done1 && !g1)   begin pop_cmp(1, op1, c1, e);    g1 = 1; end
      if (done8 && !g8)   begin pop_cmp(8, op8, c8, e);    g8 = 1; end
      if (done32 && !g32) begin pop_cmp(32, op32, c32, e); g32 = 1; end
    end
    check({tag, "_all_done_in_budget"}, 32'({g1, g8, g32}), 32'b111);
    idle_check(tag, 2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_op", op1 | op8 | op32, 32'd0);
    check("rst_flags", 32'({c1, c8, c32, busy1, busy8, busy32, done1, done8, done32}), 32'd0);
    reset = 1'b0;

    run_op("imm_rot1_ff",  f_imm(4'h1, 8'hFF), 32'h0,         32'h0,  1'b0, 32'hC000_003F, 1'b1, 2,  1);
    run_op("lsl0_hold",    f_ish(5'd0, 2'b00), 32'h8000_0001, 32'h0,  1'b1, 32'h8000_0001, 1'b1, 0,  2);
    run_op("lsr0_is_32",   f_ish(5'd0, 2'b01), 32'h8000_0000, 32'h0,  1'b0, 32'h0,         1'b1, 32, 1);
    run_op("reg_asr_40",   f_rsh(2'b10),       32'h8000_0000, 32'h40, 1'b0, 32'hFFFF_FFFF, 1'b1, 32, 1);
    run_op("reg_lsl_33",   f_rsh(2'b00),       32'h8000_0000, 32'd33, 1'b1, 32'h0,         1'b0, 0,  1);
    run_op("reg_ror_20",   f_rsh(2'b11),       32'h8000_0000, 32'h20, 1'b0, 32'h8000_0000, 1'b1, 0,  1);
    run_op("rrx",          f_ish(5'd0, 2'b11), 32'h0000_0003, 32'h0,  1'b1, 32'h8000_0001, 1'b1, 1,  1);
    run_op("lsl4",         f_ish(5'd4, 2'b00), 32'h1234_5678, 32'h0,  1'b0, 32'h2345_6780, 1'b1, 4,  1);
    run_op("asr4",         f_ish(5'd4, 2'b10), 32'h8000_00F8, 32'h0,  1'b0, 32'hF800_000F, 1'b1, 4,  1);
    run_op("reg_lsr_32",   f_rsh(2'b01),       32'h8000_0001, 32'd32, 1'b0, 32'h0,         1'b1, 32, 1);
    run_op("reg_lsl_32",   f_rsh(2'b00),       32'h0000_0001, 32'd32, 1'b0, 32'h0,         1'b1, 32, 1);
    run_op("lsr31",        f_ish(5'd31, 2'b01),32'h8000_0000, 32'h0,  1'b0, 32'h0000_0001, 1'b0, 31, 1);
    run_op("imm_rot0",     f_imm(4'h0, 8'h80), 32'h0,         32'h0,  1'b1, 32'h0000_0080, 1'b1, 0,  1);
    run_op("non_dp",       32'h0000_0090,      32'hDEAD_BEEF, 32'h5,  1'b0, 32'hDEAD_BEEF, 1'b0, 0,  1);
    run_op("reg_asr_0",    f_rsh(2'b10),       32'h8000_0000, 32'h0,  1'b0, 32'h8000_0000, 1'b0, 0,  1);
    run_op("reg_ror_8",    f_rsh(2'b11),       32'h1234_5678, 32'd8,  1'b0, 32'h7812_3456, 1'b0, 8,  1);

    // Abort a long shift with reset: sampled at the fifth edge after start
    @(negedge clk);
    instr  = f_ish(5'd20, 2'b00);
    rm_val = 32'hFFFF_FFFF;
    rs_val = 32'h0;
    c_in   = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("abort_s1_busy", 32'(busy1), 32'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'({busy1, busy8, busy32}), 32'd0);
    check("abort_done", 32'({done1, done8, done32}), 32'd0);
    check("abort_op", op1 | op8 | op32, 32'd0);
    check("abort_carry", 32'({c1, c8, c32}), 32'd0);
    idle_check("abort", 2);

    run_op("after_abort_lsl1", f_ish(5'd1, 2'b00), 32'h0000_0001, 32'h0, 1'b1, 32'h0000_0002, 1'b0, 1, 1);

    check("queues_drained", 32'(q1.size() + q8.size() + q32.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shifter_operand_unit.md
Name: shifter_operand_unit

Overview:
- Iterative ARM addressing-mode-1 operand generator; sits directly upstream of the execute-stage ALU.
- Decodes the data-processing instruction's operand-2 field, shifts or rotates Rm (or the 8-bit immediate) over multiple cycles, and presents shifter_operand and shifter_carry_out to the ALU's B and shifter_carry_out inputs.
- Uses a start/busy/done handshake, so the pipeline stalls while a shift is in progress.

Parameters:
STEP, 1, bit positions shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16, 32.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
instr  input  32  data-processing instruction; uses bits [25], [11:0]
rm_val  input  32  Rm register value
rs_val  input  32  Rs register value; only [7:0] is used
c_in  input  1  current CPSR C flag
shifter_operand  output  32  result, fed to ALU B
shifter_carry_out  output  1  shifter carry, fed to ALU
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse when the result is valid

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; shifter_operand=0; shifter_carry_out=0; busy=0; done=0. A reset in any state, including mid-SHIFT, aborts the operation and discards the partial result.
- States:
  - IDLE: start=1 latches operands and computes the effective count n (0..32), working register W, fill mode and initial carry; then goes to SHIFT if n>0, else DONE.
  - SHIFT: each cycle shifts W by k=min(n,STEP), sets carry to the last bit shifted out, and decrements n by k. When n reaches 0, goes to DONE.
  - DONE: done=1 for exactly one cycle; then IDLE.
- start in SHIFT or DONE is ignored (not queued).
- Latency: start sampled at edge t gives done high during cycle t+1+ceil(n/STEP).
- Outputs hold their last value from DONE until the next operation's DONE. The ALU may sample them on done or any later cycle.
- Immediate (instr[25]=1):
  - W = zero-extended imm8 = instr[7:0]; rotate right by n = 2*instr[11:8].
  - Initial carry = c_in. With n=0, the carry stays c_in. Otherwise the carry ends as operand[31].
- Immediate shift (instr[25]=0, instr[4]=0): amount = instr[11:7]; type = instr[6:5].
  - LSL #0: n=0, result Rm, carry c_in.
  - LSR #0 means LSR #32: result 0, carry Rm[31].
  - ASR #0 means ASR #32: result all Rm[31], carry Rm[31].
  - ROR #0 is RRX: n=1, fill bit c_in, result {c_in,Rm[31:1]}, carry Rm[0].
- Register shift (instr[25]=0, instr[4]=1, instr[7]=0): r = rs_val[7:0].
  - r=0 (any type): n=0, result Rm, carry c_in.
  - LSL or LSR with r=32: n=32. The result is 0; carry is Rm[0] for LSL and Rm[31] for LSR.
  - LSL or LSR with r>32: load result 0 with carry 0 directly; n=0.
  - ASR with r≥32: clamp n to 32; result all Rm[31], carry Rm[31].
  - ROR with r≠0 and r[4:0]=0: n=0, result Rm, carry Rm[31].
  - ROR otherwise: n = r[4:0].
- Fill rules: LSL fills with 0; LSR fills with 0; ASR fills with W[31] as captured at latch; ROR fills from W's own low bits.
- instr[25]=0 with instr[7]=1 and instr[4]=1 is not a data-processing operand. Treat it as n=0, result Rm, carry c_in.
- A shift by exactly 32 in STEP=32 mode completes in one SHIFT cycle.

Decomposition:
- Shared package (arm_pkg):
  - shift type codes: LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11
  - state encoding: IDLE, SHIFT, DONE
  - instruction field position constants: I_BIT=25, REG_SHIFT_BIT=4, ROT_MSB/LSB, SHAMT_MSB/LSB, TYPE_MSB/LSB
- Sub-module shifter_step: combinational. Takes W, type, k (1..STEP) and fill bit; returns W' and carry. The FSM, counter and latches stay in the top module.

Test Plan:
1. STEP=1: instr[25]=1, rot=4'h1, imm8=8'hFF, start at t → shifter_operand=0xC000003F, carry=1, done at t+3.
2. Immediate LSL #0, Rm=0x80000001, c_in=1 → operand 0x80000001, carry=1, done at t+1. Also: start held high during the following DONE is ignored.
3. Immediate LSR #0, Rm=0x80000000 → operand 0, carry=1. Done at t+33 with STEP=1 and at t+5 with STEP=8.
4. Register shifts, Rm=0x80000000:
   - ASR with rs=0x40 → 0xFFFFFFFF, carry=1.
   - LSL with rs=33 → 0, carry=0, done at t+1.
   - ROR with rs=0x20 → 0x80000000, carry=1.
5. RRX: ROR #0, Rm=0x00000003, c_in=1 → 0x80000001, carry=1, done at t+2.
6. Start LSL #20 with STEP=1, then assert reset at t+5 → next cycle: IDLE, busy=0, done=0, outputs 0. A new start (LSL #1, Rm=1) then gives 0x00000002, carry=0.
